// File: rtl/core_pkg.sv
// Shared widths, the ID/EX payload layout and execute-command constants for the ARM core.
package core_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_CMD_W      = 4;
  localparam int DEF_SHIFT_W    = 12;
  localparam int DEF_IMM_W      = 24;

  localparam logic [DEF_CMD_W-1:0] EXE_CMD_NOP = '0;

  typedef struct packed {
    logic                      wb_en;
    logic                      mem_r_en;
    logic                      mem_w_en;
    logic                      b;
    logic                      s;
    logic                      imm;
    logic                      carry;
    logic [DEF_CMD_W-1:0]      exe_cmd;
    logic [DEF_REG_ADDR_W-1:0] dest;
    logic [DEF_REG_ADDR_W-1:0] src1;
    logic [DEF_REG_ADDR_W-1:0] src2;
    logic [DEF_SHIFT_W-1:0]    shift_operand;
    logic [DEF_IMM_W-1:0]      signed_imm_24;
    logic [DEF_DATA_W-1:0]     pc;
    logic [DEF_DATA_W-1:0]     val_rn;
    logic [DEF_DATA_W-1:0]     val_rm;
  } id_ex_payload;

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic payload register with a valid bit; clr zeroes both, load writes both.
module pipe_skid_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         valid_d;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load) begin
      valid_d = valid_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and bubble insertion.
// Define SKID_BUFFER_EN to add a one-entry skid slot and a registered in_ready.
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CMD_W      = DEF_CMD_W,
  parameter int SHIFT_W    = DEF_SHIFT_W,
  parameter int IMM_W      = DEF_IMM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic                  imm_in,
  input  logic                  carry_in,
  input  logic [CMD_W-1:0]      exe_cmd_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [SHIFT_W-1:0]    shift_operand_in,
  input  logic [IMM_W-1:0]      signed_imm_24_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  b,
  output logic                  s,
  output logic                  imm,
  output logic                  carry_out,
  output logic [CMD_W-1:0]      exe_cmd,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [SHIFT_W-1:0]    shift_operand,
  output logic [IMM_W-1:0]      signed_imm_24,
  output logic [DATA_W-1:0]     pc,
  output logic [DATA_W-1:0]     val_rn,
  output logic [DATA_W-1:0]     val_rm
);

  localparam int PW = 7 + CMD_W + 3 * REG_ADDR_W + SHIFT_W + IMM_W + 3 * DATA_W;

  // Side-effect bits (wb_en, mem_r_en, mem_w_en, b, s) occupy the top five payload bits.
  function automatic logic [PW-1:0] make_bubble(input logic [PW-1:0] p);
    return {5'b0, p[PW-6:0]};
  endfunction

  logic [PW-1:0] payload_in;
  logic          acc;
  logic          con;

  logic          main_load;
  logic          main_valid_in;
  logic [PW-1:0] main_data_in;
  logic          main_valid;
  logic [PW-1:0] main_data;

  assign payload_in = {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in,
                       exe_cmd_in, dest_in, src1_in, src2_in, shift_operand_in,
                       signed_imm_24_in, pc_in, val_rn_in, val_rm_in};

  assign acc = in_valid & in_ready;
  assign con = main_valid & out_ready;

`ifdef SKID_BUFFER_EN
  logic          skid_load;
  logic          skid_valid_in;
  logic [PW-1:0] skid_data_in;
  logic          skid_valid;
  logic [PW-1:0] skid_data;
  logic          main_free;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
  assign in_ready  = ~skid_valid;
  assign main_free = ~main_valid | out_ready;

  always_comb begin
    main_load     = 1'b0;
    main_valid_in = 1'b0;
    main_data_in  = payload_in;
    skid_load     = 1'b0;
    skid_valid_in = 1'b0;
    skid_data_in  = payload_in;
    if (!flush) begin
      if (main_free) begin
        if (skid_valid) begin
          main_load     = 1'b1;
          main_valid_in = 1'b1;
          main_data_in  = skid_data;
          skid_load     = 1'b1;
          skid_valid_in = acc;
          skid_data_in  = acc ? payload_in : skid_data;
        end else if (acc) begin
          main_load     = 1'b1;
          main_valid_in = 1'b1;
        end else if (con) begin
          main_load     = 1'b1;
          main_data_in  = make_bubble(main_data);
        end
      end else if (acc) begin
        skid_load     = 1'b1;
        skid_valid_in = 1'b1;
      end
    end
  end

  pipe_skid_slot #(.W(PW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .load     (skid_load),
    .valid_in (skid_valid_in),
    .data_in  (skid_data_in),
    .valid_q  (skid_valid),
    .data_q   (skid_data)
  );
`else
  assign in_ready = ~main_valid | out_ready;

  always_comb begin
    main_load     = 1'b0;
    main_valid_in = 1'b0;
    main_data_in  = payload_in;
    if (!flush) begin
      if (acc) begin
        main_load     = 1'b1;
        main_valid_in = 1'b1;
      end else if (con) begin
        main_load     = 1'b1;
        main_data_in  = make_bubble(main_data);
      end
    end
  end
`endif

  pipe_skid_slot #(.W(PW)) u_main (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .load     (main_load),
    .valid_in (main_valid_in),
    .data_in  (main_data_in),
    .valid_q  (main_valid),
    .data_q   (main_data)
  );

  assign out_valid = main_valid;
  assign {wb_en, mem_r_en, mem_w_en, b, s, imm, carry_out, exe_cmd, dest, src1, src2,
          shift_operand, signed_imm_24, pc, val_rn, val_rm} = main_data;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (default build; skid scenario under SKID_BUFFER_EN).
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en, mem_r_en, mem_w_en, b, s, imm, carry_out;
  logic [3:0]  exe_cmd, dest, src1, src2;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc, val_rn, val_rm;

  int total = 0;
  int bad   = 0;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .carry_in(carry_in),
    .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
    .carry_out(carry_out), .exe_cmd(exe_cmd), .dest(dest), .src1(src1), .src2(src2),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .pc(pc), .val_rn(val_rn), .val_rm(val_rm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0; carry_in = 0;
    exe_cmd_in = 0; dest_in = 0; src1_in = 0; src2_in = 0;
    shift_operand_in = 0; signed_imm_24_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    #2;
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    total++; if ({wb_en, pc, val_rn, dest} !== '0) begin bad++; $display("FAIL reset_fields got wb=%0b pc=%h rn=%h dest=%h want 0", wb_en, pc, val_rn, dest); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; wb_en_in = 1; mem_r_en_in = 1; pc_in = 32'h60; val_rn_in = 32'h77; dest_in = 4'd3;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || pc !== 32'h60) begin bad++; $display("FAIL areset_load got v=%0b pc=%h want 1 00000060", out_valid, pc); end
    #2;
    rst = 1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_ctrl got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
    total++; if ({wb_en, mem_r_en, pc, val_rn, dest} !== '0) begin bad++; $display("FAIL areset_fields got wb=%0b mr=%0b pc=%h rn=%h want 0", wb_en, mem_r_en, pc, val_rn); end
    rst = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC; pcs[3] = 32'h10;
    do_reset();
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      pc_in = pcs[i];
      src1_in = 4'(i + 1);
      tick();
      total++; if (out_valid !== 1'b1 || pc !== pcs[i] || src1 !== 4'(i + 1)) begin
        bad++; $display("FAIL b2b_%0d got v=%0b pc=%h src1=%h want 1 %h %h", i, out_valid, pc, src1, pcs[i], 4'(i + 1));
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got %0b want 1", i, in_ready); end
    end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0 || pc !== 32'h10) begin bad++; $display("FAIL b2b_drain got v=%0b pc=%h want 0 00000010", out_valid, pc); end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1; wb_en_in = 1; dest_in = 4'd5; pc_in = 32'h20; val_rn_in = 32'h1234;
    tick();
    total++; if (out_valid !== 1'b1 || wb_en !== 1'b1 || dest !== 4'd5) begin bad++; $display("FAIL stall_load got v=%0b wb=%0b dest=%0d want 1 1 5", out_valid, wb_en, dest); end
    dest_in = 4'd6; pc_in = 32'h24; val_rn_in = 32'h5678;
`ifdef SKID_BUFFER_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_skid_ready got %0b want 1", in_ready); end
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got %0b want 0", in_ready); end
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || pc !== 32'h20 || dest !== 4'd5 || val_rn !== 32'h1234 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d got v=%0b pc=%h dest=%0d rn=%h rdy=%0b want 1 00000020 5 00001234 0", i, out_valid, pc, dest, val_rn, in_ready);
      end
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || pc !== 32'h24 || dest !== 4'd6 || val_rn !== 32'h5678) begin
      bad++; $display("FAIL stall_release got v=%0b pc=%h dest=%0d rn=%h want 1 00000024 6 00005678", out_valid, pc, dest, val_rn);
    end
    tick();
    total++; if (out_valid !== 1'b0 || wb_en !== 1'b0 || pc !== 32'h24) begin bad++; $display("FAIL stall_nodup got v=%0b wb=%0b pc=%h want 0 0 00000024", out_valid, wb_en, pc); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; wb_en_in = 1; pc_in = 32'h40; val_rn_in = 32'hABCD; exe_cmd_in = 4'h9;
    tick();
    total++; if (out_valid !== 1'b1 || pc !== 32'h40) begin bad++; $display("FAIL flush_pre got v=%0b pc=%h want 1 00000040", out_valid, pc); end
    mem_w_en_in = 1; pc_in = 32'h44; flush = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || mem_w_en !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL flush_ctrl got v=%0b mw=%0b wb=%0b want 0 0 0", out_valid, mem_w_en, wb_en); end
    total++; if ({pc, val_rn, exe_cmd} !== '0) begin bad++; $display("FAIL flush_fields got pc=%h rn=%h cmd=%h want 0", pc, val_rn, exe_cmd); end
    tick();
    total++; if (out_valid !== 1'b0 || pc !== 32'h0 || mem_w_en !== 1'b0) begin bad++; $display("FAIL flush_dropped got v=%0b pc=%h mw=%0b want 0 0 0", out_valid, pc, mem_w_en); end
  endtask

  task automatic test_drain();
    do_reset();
    out_ready = 1; in_valid = 1;
    wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; imm_in = 1; carry_in = 1;
    exe_cmd_in = 4'hA; val_rn_in = 32'hDEADBEEF; pc_in = 32'h50;
    tick();
    total++; if ({wb_en, mem_r_en, mem_w_en, b, s, imm, carry_out} !== 7'h7F || val_rn !== 32'hDEADBEEF) begin
      bad++; $display("FAIL drain_load got ctrl=%b rn=%h want 1111111 deadbeef", {wb_en, mem_r_en, mem_w_en, b, s, imm, carry_out}, val_rn);
    end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0 || {wb_en, mem_r_en, mem_w_en, b, s} !== 5'b0) begin
      bad++; $display("FAIL drain_bubble got v=%0b ctrl=%b want 0 00000", out_valid, {wb_en, mem_r_en, mem_w_en, b, s});
    end
    total++; if (val_rn !== 32'hDEADBEEF || pc !== 32'h50 || exe_cmd !== 4'hA || imm !== 1'b1) begin
      bad++; $display("FAIL drain_hold got rn=%h pc=%h cmd=%h imm=%0b want deadbeef 00000050 a 1", val_rn, pc, exe_cmd, imm);
    end
  endtask

`ifdef SKID_BUFFER_EN
  task automatic test_skid_order();
    do_reset();
    in_valid = 1; pc_in = 32'hA;
    tick();
    total++; if (in_ready !== 1'b1 || pc !== 32'hA) begin bad++; $display("FAIL skid_first got rdy=%0b pc=%h want 1 0000000a", in_ready, pc); end
    pc_in = 32'hB;
    tick();
    in_valid = 0;
    total++; if (in_ready !== 1'b0 || pc !== 32'hA) begin bad++; $display("FAIL skid_full got rdy=%0b pc=%h want 0 0000000a", in_ready, pc); end
    out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b1 || pc !== 32'hB || in_ready !== 1'b1) begin bad++; $display("FAIL skid_second got v=%0b pc=%h rdy=%0b want 1 0000000b 1", out_valid, pc, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_empty got v=%0b want 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_drain();
`ifdef SKID_BUFFER_EN
    test_skid_order();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
